// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, LCR field
// offsets, word-length encodings and the framing parity helper.
package uart_pkg;

  localparam int OVERSAMPLE_DEFAULT = 16;

  localparam int LCR_WLS_LSB = 0;
  localparam int LCR_STB     = 2;
  localparam int LCR_PEN     = 3;
  localparam int LCR_EPS     = 4;
  localparam int LCR_STICK   = 5;
  localparam int LCR_BREAK   = 6;

  typedef enum logic [1:0] {
    WLS_5 = 2'b00,
    WLS_6 = 2'b01,
    WLS_7 = 2'b10,
    WLS_8 = 2'b11
  } wls_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  function automatic logic [7:0] wls_mask(input logic [1:0] wls);
    case (wls)
      WLS_5:   return 8'h1F;
      WLS_6:   return 8'h3F;
      WLS_7:   return 8'h7F;
      default: return 8'hFF;
    endcase
  endfunction

  // Parity over the transmitted data bits only; stick mode forces ~EPS.
  function automatic logic tx_parity(input logic [7:0] data, input logic [1:0] wls,
                                     input logic eps, input logic stick);
    logic ones_odd;
    ones_odd = ^(data & wls_mask(wls));
    if (stick) begin
      return ~eps;
    end else if (eps) begin
      return ones_odd;
    end else begin
      return ~ones_odd;
    end
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO feeding the transmit shifter; used only when UART_TX_FIFO_EN
// is defined. DEPTH must be a power of two.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] rd_data_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             push_s;
  logic             pop_s;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_s    = wr_i && !full_o;
  assign pop_s     = rd_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // Storage array
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

  // Read/write pointers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmit path: THR (or a TX FIFO when UART_TX_FIFO_EN is defined) feeding a
// framing FSM and shifter that drive a registered TXD from a 16x baud strobe.
module uart_transmitter
  import uart_pkg::*;
#(
`ifdef UART_TX_FIFO_EN
  parameter int FIFO_DEPTH = 16,
`endif
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic       BCLK,
  input  logic       RST,
  input  logic       baud_tick,
  input  logic       thr_wr,
  input  logic [7:0] thr_data,
  input  logic [6:0] lcr,
  output logic       txd,
  output logic       thr_empty,
  output logic       tsr_empty
);

  localparam int TICK_W = $clog2(2 * OVERSAMPLE);
  localparam logic [TICK_W-1:0] BIT_LAST     = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] STOP_LAST_15 = TICK_W'(OVERSAMPLE + OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] STOP_LAST_2  = TICK_W'(2 * OVERSAMPLE - 1);

  tx_state_e         state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d, tick_last_s;
  logic [2:0]        bit_q, bit_d, bit_last_s;
  logic [7:0]        shift_q, shift_d;
  logic [3:0]        cfg_q, cfg_d;
  logic              par_q, par_d;
  logic              txd_q, txd_d;
  logic              line_s;
  logic              load_s;
  logic              bit_end_s;
  logic              src_empty_s;
  logic [7:0]        src_data_s;

  // Cfg holds WLS/STB/PEN for the frame in flight; parity is resolved at load.
  assign bit_last_s = 3'd4 + {1'b0, cfg_q[LCR_WLS_LSB +: 2]};
  assign bit_end_s  = baud_tick && (tick_q == tick_last_s);

  // Length of the current bit in ticks (stop may be 1, 1.5 or 2 bit times)
  always_comb begin
    tick_last_s = BIT_LAST;
    if (state_q == ST_STOP && cfg_q[LCR_STB]) begin
      if (cfg_q[LCR_WLS_LSB +: 2] == WLS_5) begin
        tick_last_s = STOP_LAST_15;
      end else begin
        tick_last_s = STOP_LAST_2;
      end
    end else begin
      tick_last_s = BIT_LAST;
    end
  end

  // Framing FSM next state, counters, shifter and TXD value
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    cfg_d   = cfg_q;
    par_d   = par_q;
    load_s  = 1'b0;
    line_s  = 1'b1;

    if (state_q != ST_IDLE && baud_tick) begin
      if (bit_end_s) begin
        tick_d = '0;
      end else begin
        tick_d = tick_q + 1'b1;
      end
    end else begin
      tick_d = tick_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (!src_empty_s) begin
          load_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == bit_last_s) begin
            bit_d   = 3'd0;
            state_d = cfg_q[LCR_PEN] ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          state_d = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          if (!src_empty_s) begin
            load_s = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A load restarts the tick count, so a coincident tick is not counted.
    if (load_s) begin
      state_d = ST_START;
      tick_d  = '0;
      bit_d   = 3'd0;
      shift_d = src_data_s;
      cfg_d   = lcr[3:0];
      par_d   = tx_parity(src_data_s, lcr[LCR_WLS_LSB +: 2], lcr[LCR_EPS], lcr[LCR_STICK]);
    end else begin
      cfg_d = cfg_q;
    end

    case (state_d)
      ST_IDLE:   line_s = 1'b1;
      ST_START:  line_s = 1'b0;
      ST_DATA:   line_s = shift_d[0];
      ST_PARITY: line_s = par_d;
      ST_STOP:   line_s = 1'b1;
      default:   line_s = 1'b1;
    endcase

    txd_d = lcr[LCR_BREAK] ? 1'b0 : line_s;
  end

  // Framing state registers
  always_ff @(posedge BCLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      cfg_q   <= 4'h0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      cfg_q   <= cfg_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
    end
  end

`ifdef UART_TX_FIFO_EN
  logic fifo_full_s;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk_i     (BCLK),
    .rst_i     (RST),
    .wr_i      (thr_wr && !fifo_full_s),
    .wr_data_i (thr_data),
    .rd_i      (load_s),
    .full_o    (fifo_full_s),
    .empty_o   (src_empty_s),
    .rd_data_o (src_data_s)
  );
`else
  logic [7:0] thr_q, thr_d;
  logic       thr_empty_q, thr_empty_d;

  // Single holding register; a write always wins and overwrites a pending byte
  always_comb begin
    thr_d       = thr_q;
    thr_empty_d = thr_empty_q;
    if (thr_wr) begin
      thr_d       = thr_data;
      thr_empty_d = 1'b0;
    end else if (load_s) begin
      thr_empty_d = 1'b1;
    end else begin
      thr_empty_d = thr_empty_q;
    end
  end

  // Holding register state
  always_ff @(posedge BCLK) begin
    if (RST) begin
      thr_q       <= 8'h00;
      thr_empty_q <= 1'b1;
    end else begin
      thr_q       <= thr_d;
      thr_empty_q <= thr_empty_d;
    end
  end

  assign src_empty_s = thr_empty_q;
  assign src_data_s  = thr_q;
`endif

  assign txd       = txd_q;
  assign thr_empty = src_empty_s;
  assign tsr_empty = src_empty_s && (state_q == ST_IDLE);

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: directed framing cases plus random
// bytes/LCR settings, compared tick-by-tick against a frame-level model.
module tb_uart_transmitter;

  localparam int OS = 16;

  logic       BCLK = 1'b0;
  logic       RST;
  logic       baud_tick;
  logic       thr_wr;
  logic [7:0] thr_data;
  logic [6:0] lcr;
  logic       txd;
  logic       thr_empty;
  logic       tsr_empty;

  int total = 0;
  int bad   = 0;
  int ph;
  bit rec_q[$];
  bit exp_q[$];

  uart_transmitter dut (
    .BCLK      (BCLK),
    .RST       (RST),
    .baud_tick (baud_tick),
    .thr_wr    (thr_wr),
    .thr_data  (thr_data),
    .lcr       (lcr),
    .txd       (txd),
    .thr_empty (thr_empty),
    .tsr_empty (tsr_empty)
  );

  always #5 BCLK = ~BCLK;

  // baud_tick: one cycle in every four
  initial begin
    baud_tick = 1'b0;
    ph = 0;
    forever begin
      @(posedge BCLK);
      #1;
      ph = (ph + 1) % 4;
      baud_tick = (ph == 0);
    end
  end

  // Line recorder: txd at every tick while the transmitter is busy
  always @(negedge BCLK) begin
    if (baud_tick === 1'b1 && tsr_empty === 1'b0) begin
      rec_q.push_back(txd);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge BCLK);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_bits(input bit v, input int n);
    repeat (n) exp_q.push_back(v);
  endtask

  // Frame model: start, LSB-first data, optional parity, stop; each as tick samples
  task automatic model_frame(input logic [7:0] d, input logic [5:0] l);
    int nbits;
    int ones;
    bit p;
    nbits = 5 + int'(l[1:0]);
    ones  = 0;
    push_bits(1'b0, OS);
    for (int i = 0; i < nbits; i++) begin
      push_bits(d[i], OS);
      ones += int'(d[i]);
    end
    if (l[3]) begin
      if (l[5])      p = !l[4];
      else if (l[4]) p = (ones % 2 == 1);
      else           p = (ones % 2 == 0);
      push_bits(p, OS);
    end
    if (!l[2])           push_bits(1'b1, OS);
    else if (nbits == 5) push_bits(1'b1, OS + OS / 2);
    else                 push_bits(1'b1, 2 * OS);
  endtask

  task automatic align_tick();
    for (int k = 0; k < 8 && baud_tick !== 1'b1; k++) step();
  endtask

  task automatic do_write(input logic [7:0] d);
    thr_data = d;
    thr_wr   = 1'b1;
    step();
    thr_wr   = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (tsr_empty !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_timeout"}, (n < budget) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic check_frames(input string tag, input int budget);
    int mism;
    mism = 0;
    wait_idle(tag, budget);
    chk({tag, "_len"}, rec_q.size(), exp_q.size());
    for (int i = 0; i < rec_q.size() && i < exp_q.size(); i++) begin
      if (rec_q[i] !== exp_q[i]) mism++;
    end
    chk({tag, "_bits"}, mism, 0);
    rec_q.delete();
    exp_q.delete();
  endtask

  task automatic send(input logic [7:0] d, input logic [6:0] l, input string tag);
    rec_q.delete();
    lcr = l;
    align_tick();
    step();
    do_write(d);
    chk({tag, "_thr_full"}, thr_empty, 1'b0);
    step();
    chk({tag, "_ld_thr"}, thr_empty, 1'b1);
    chk({tag, "_ld_tsr"}, tsr_empty, 1'b0);
    model_frame(d, l[5:0]);
    check_frames(tag, 2000);
  endtask

  initial begin
    int nz;
    logic [5:0] la;
    logic [7:0] db;
    RST = 1'b1; thr_wr = 1'b0; thr_data = 8'h00; lcr = 7'h03;
    repeat (3) step();
    chk("rst_txd", txd, 1'b1);
    chk("rst_thr_empty", thr_empty, 1'b1);
    chk("rst_tsr_empty", tsr_empty, 1'b1);
    RST = 1'b0;
    step();

    send(8'h55, 7'h03, "8N1_55");
    send(8'h41, 7'h1A, "7E1_41");
    send(8'h41, 7'h0A, "7O1_41");
    send(8'hB6, 7'h04, "5N2");
    send(8'h2D, 7'h05, "6N2");
    send(8'h96, 7'h2B, "8stick");

    // load coincides with a tick: that tick is idle, START still lasts 16 ticks
    rec_q.delete();
    lcr = 7'h03;
    align_tick();
    repeat (3) step();
    do_write(8'hC3);
    exp_q.push_back(1'b1);
    model_frame(8'hC3, 6'h03);
    check_frames("tick_on_load", 2000);

    // random frames; lcr is changed after load and must not affect the frame
    for (int r = 0; r < 8; r++) begin
      la = 6'($urandom);
      db = 8'($urandom);
      lcr = {1'b0, la};
      align_tick();
      step();
      do_write(db);
      step();
      lcr = {1'b0, 6'($urandom)};
      model_frame(db, la);
      check_frames($sformatf("rand%0d", r), 2000);
    end

`ifdef UART_TX_FIFO_EN
    lcr = 7'h03;
    align_tick();
    step();
    for (int i = 0; i < 18; i++) do_write(8'(i * 29 + 3));
    for (int i = 0; i < 17; i++) model_frame(8'(i * 29 + 3), 6'h03);
    check_frames("fifo", 20000);
    chk("fifo_empty_end", thr_empty, 1'b1);
`else
    // back-to-back: write on load cycle keeps new byte; later write overwrites it
    lcr = 7'h03;
    align_tick();
    step();
    do_write(8'hA5);
    do_write(8'h99);
    chk("same_cycle_load_thr", thr_empty, 1'b0);
    do_write(8'h3C);
    model_frame(8'hA5, 6'h03);
    model_frame(8'h3C, 6'h03);
    check_frames("b2b", 4000);
`endif

    // set_break mid-frame forces txd low without disturbing frame timing
    lcr = 7'h03;
    align_tick();
    step();
    do_write(8'h55);
    repeat (80) step();
    lcr = 7'h43;
    step();
    nz = 0;
    for (int i = 0; i < 30; i++) begin
      if (txd !== 1'b0) nz++;
      step();
    end
    chk("break_low", nz, 0);
    lcr = 7'h03;
    wait_idle("break_frame", 2000);
    chk("break_frame_len", rec_q.size(), 10 * OS);
    rec_q.delete();

    // bytes are consumed while break is held
    lcr = 7'h43;
    align_tick();
    step();
    do_write(8'hF0);
    wait_idle("break_consume", 2000);
    nz = 0;
    foreach (rec_q[i]) if (rec_q[i] !== 1'b0) nz++;
    chk("break_consume_len", rec_q.size(), 10 * OS);
    chk("break_consume_low", nz, 0);
    chk("break_consume_thr", thr_empty, 1'b1);
    rec_q.delete();

    // reset in the middle of DATA discards the frame and the pending byte
    lcr = 7'h03;
    align_tick();
    step();
    do_write(8'h00);
    do_write(8'h77);
    repeat (100) step();
    chk("pre_reset_txd", txd, 1'b0);
    RST = 1'b1;
    step();
    chk("mid_rst_txd", txd, 1'b1);
    chk("mid_rst_thr_empty", thr_empty, 1'b1);
    chk("mid_rst_tsr_empty", tsr_empty, 1'b1);
    RST = 1'b0;
    rec_q.delete();
    repeat (200) step();
    chk("post_rst_idle", tsr_empty, 1'b1);
    chk("post_rst_no_tx", rec_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
